vl_elem_seq: RTL and testbench

VL_ELEM_SEQ -- requirements
Module: vl_elem_seq

---
 rtl/vec_pkg.sv | 31 +++
 rtl/vl_elem_counter.sv | 34 +++
 rtl/vl_elem_seq.sv | 117 +++++++++++
 tb/tb_vl_elem_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector element sequencer: default maximum
// vector length, width helpers and the sequencer state encoding.
package vec_pkg;

    localparam int MVL_DEFAULT = 16;

    // Number of bits needed to index n items (ceil(log2(n))).
    function automatic int vec_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of a vector-length value able to hold 0..mvl inclusive.
    function automatic int vl_width(input int mvl);
        return vec_clog2(mvl) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/vl_elem_counter.sv
// Element index register with load-zero / increment and the last-element
// compare against the captured vector length.
module vl_elem_counter
    import vec_pkg::*;
#(
    parameter int VLW = vl_width(MVL_DEFAULT),
    parameter int IW  = vec_clog2(MVL_DEFAULT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           adv,
    input  logic [VLW-1:0] vl_snap,
    output logic [IW-1:0]  idx,
    output logic           last
);

    // Index register: cleared on a new sequence, stepped on each accepted element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (adv) begin
            idx <= idx + IW'(1);
        end
    end

    // Compare idx+1 against vl_snap so a zero length never underflows.
    always_comb begin
        last = ((VLW'(idx) + VLW'(1)) == vl_snap);
    end

endmodule

// File: rtl/vl_elem_seq.sv
// Vector element sequencer: on a start handshake it snapshots the vector
// length and offers element indices 0..vl-1 downstream with valid/ready,
// then pulses done.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; start_ready = !abort
//   RUN   | offering elem_idx downstream, advancing on each handshake
//   FIN   | one-cycle done pulse, then back to IDLE
module vl_elem_seq
    import vec_pkg::*;
#(
    parameter int MVL = MVL_DEFAULT,
    parameter int VLW = vl_width(MVL),
    parameter int IW  = vec_clog2(MVL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [VLW-1:0] vlr,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic           abort,
    output logic           elem_valid,
    input  logic           elem_ready,
    output logic [IW-1:0]  elem_idx,
    output logic           elem_last,
    output logic           busy,
    output logic           done
);

    state_t         state;
    state_t         state_nxt;
    logic [VLW-1:0] vl_snap;
    logic [VLW-1:0] vl_cap;
    logic           start_hs;
    logic           cnt_adv;
    logic           cnt_last;
    logic [IW-1:0]  cnt_idx;

    assign vl_cap   = (vlr > VLW'(MVL)) ? VLW'(MVL) : vlr;
    assign start_hs = start_valid && start_ready;

    vl_elem_counter #(
        .VLW (VLW),
        .IW  (IW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_hs),
        .adv     (cnt_adv),
        .vl_snap (vl_snap),
        .idx     (cnt_idx),
        .last    (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Vector length snapshot, frozen for the whole sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vl_snap <= '0;
        end else if (start_hs) begin
            vl_snap <= vl_cap;
        end
    end

    // Next state and outputs; abort wins over everything and suppresses done.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        elem_valid  = 1'b0;
        elem_idx    = '0;
        elem_last   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cnt_adv     = 1'b0;
        case (state)
            IDLE: begin
                start_ready = !abort;
                if (start_valid && !abort) begin
                    state_nxt = (vl_cap == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                elem_valid = 1'b1;
                busy       = 1'b1;
                elem_idx   = cnt_idx;
                elem_last  = cnt_last;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (elem_ready) begin
                    if (cnt_last) begin
                        state_nxt = FIN;
                    end else begin
                        cnt_adv = 1'b1;
                    end
                end
            end
            FIN: begin
                busy      = 1'b1;
                done      = !abort;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vl_elem_seq.sv
// Self-checking bench for vl_elem_seq: table-driven sequences with a
// scoreboard of expected elements, plus abort and reset corner cases.
module tb_vl_elem_seq;

    logic       clk;
    logic       rst;
    logic [4:0] vlr;
    logic       start_valid;
    logic       start_ready;
    logic       abort;
    logic       elem_valid;
    logic       elem_ready;
    logic [3:0] elem_idx;
    logic       elem_last;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] idx;
        logic       last;
    } elem_t;

    typedef struct {
        int vlr;
        int vlr_mid;
        bit toggle;
        bit noise;
        int exp_n;
    } vec_t;

    elem_t sb[$];
    vec_t  tbl[7];

    vl_elem_seq dut (
        .clk         (clk),
        .rst         (rst),
        .vlr         (vlr),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .abort       (abort),
        .elem_valid  (elem_valid),
        .elem_ready  (elem_ready),
        .elem_idx    (elem_idx),
        .elem_last   (elem_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_expected(input int n);
        elem_t e;
        for (int i = 0; i < n; i++) begin
            e.idx  = 4'(i);
            e.last = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic pop_compare();
        elem_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("elem_idx", elem_idx, e.idx);
            chk("elem_last", elem_last, e.last);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         last_hs;
        int         got;
        bit         seen_done;
        bit         prev_stall;
        logic [3:0] prev_idx;
        logic       prev_last;
        last_hs    = 0;
        got        = 0;
        seen_done  = 0;
        prev_stall = 0;
        prev_idx   = '0;
        prev_last  = 1'b0;
        @(negedge clk);
        vlr         = 5'(v.vlr);
        start_valid = 1'b1;
        elem_ready  = 1'b0;
        abort       = 1'b0;
        #1;
        chk("start_ready_idle", start_ready, 1);
        chk("busy_idle", busy, 0);
        push_expected(v.exp_n);
        for (int cyc = 1; cyc <= 100 && !seen_done; cyc++) begin
            @(negedge clk);
            start_valid = v.noise;
            elem_ready  = v.toggle ? (cyc % 3 == 1) : 1'b1;
            if (cyc == 2) vlr = 5'(v.vlr_mid);
            #1;
            if (cyc == 1) chk("first_valid_lat", elem_valid, int'(v.exp_n > 0));
            if (prev_stall) begin
                chk("hold_idx", elem_idx, prev_idx);
                chk("hold_last", elem_last, prev_last);
            end
            if (elem_valid) chk("start_ready_run", start_ready, 0);
            if (done) begin
                seen_done = 1;
                chk("done_lat", cyc, last_hs + 1);
                chk("done_valid", elem_valid, 0);
                chk("done_busy", busy, 1);
                chk("sb_empty", sb.size(), 0);
            end else if (elem_valid && elem_ready) begin
                pop_compare();
                last_hs = cyc;
                got++;
            end
            prev_stall = elem_valid && !elem_ready;
            prev_idx   = elem_idx;
            prev_last  = elem_last;
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        chk("elem_count", got, v.exp_n);
        @(negedge clk);
        start_valid = 1'b0;
        elem_ready  = 1'b0;
        #1;
        chk("done_one_cycle", done, 0);
        chk("start_ready_after", start_ready, 1);
        chk("busy_after", busy, 0);
        sb.delete();
    endtask

    initial begin
        bit   reached;
        vec_t v;

        tbl[0] = '{vlr: 5,  vlr_mid: 5,  toggle: 0, noise: 0, exp_n: 5};
        tbl[1] = '{vlr: 20, vlr_mid: 20, toggle: 0, noise: 0, exp_n: 16};
        tbl[2] = '{vlr: 0,  vlr_mid: 0,  toggle: 0, noise: 0, exp_n: 0};
        tbl[3] = '{vlr: 4,  vlr_mid: 2,  toggle: 1, noise: 0, exp_n: 4};
        tbl[4] = '{vlr: 16, vlr_mid: 1,  toggle: 0, noise: 1, exp_n: 16};
        tbl[5] = '{vlr: 1,  vlr_mid: 1,  toggle: 1, noise: 1, exp_n: 1};
        tbl[6] = '{vlr: 31, vlr_mid: 0,  toggle: 1, noise: 0, exp_n: 16};

        rst         = 1'b1;
        vlr         = '0;
        start_valid = 1'b0;
        abort       = 1'b0;
        elem_ready  = 1'b0;
        #12;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_elem_valid", elem_valid, 0);
        chk("rst_elem_idx", elem_idx, 0);
        chk("rst_elem_last", elem_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        abort = 1'b1;
        #1;
        chk("idle_abort_start_ready", start_ready, 0);
        abort = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_vec(tbl[t]);
        end

        // Abort while idx 3 is offered with elem_ready high.
        @(negedge clk);
        vlr         = 5'd8;
        start_valid = 1'b1;
        #1;
        chk("abort_seq_start", start_ready, 1);
        push_expected(8);
        reached = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start_valid = 1'b0;
            elem_ready  = 1'b1;
            #1;
            if (elem_valid && elem_idx == 4'd3) begin
                abort = 1'b1;
                #1;
                chk("abort_no_done", done, 0);
                chk("abort_start_ready", start_ready, 0);
                reached = 1;
                break;
            end else if (elem_valid) begin
                pop_compare();
            end
        end
        if (!reached) chk("abort_reach_idx3", 0, 1);
        @(negedge clk);
        abort      = 1'b0;
        elem_ready = 1'b0;
        #1;
        chk("abort_idle_valid", elem_valid, 0);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
        chk("abort_idle_start_ready", start_ready, 1);
        sb.delete();
        v = '{vlr: 3, vlr_mid: 3, toggle: 0, noise: 0, exp_n: 3};
        run_vec(v);

        // Reset pulse mid-sequence takes effect between clock edges.
        @(negedge clk);
        vlr         = 5'd8;
        start_valid = 1'b1;
        #1;
        chk("rst_seq_start", start_ready, 1);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            start_valid = 1'b0;
            elem_ready  = 1'b1;
            #1;
        end
        chk("rst_seq_running", elem_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", elem_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_idx", elem_idx, 0);
        chk("async_rst_last", elem_last, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_start_ready", start_ready, 1);
        @(negedge clk);
        rst        = 1'b0;
        elem_ready = 1'b0;
        v = '{vlr: 2, vlr_mid: 2, toggle: 0, noise: 0, exp_n: 2};
        run_vec(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
